mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter onto a single memory port.
// Optional watchdog abort is enabled by defining ARB_TIMEOUT_EN.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,

    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [3:0]  ls_wstrb,
    output logic        ls_ack,
    output logic [31:0] ls_rdata,

    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,

    output logic        timeout
);

    localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_LS,
        RESP
    } state_t;

    state_t          r_state;
    logic [SW-1:0]   r_streak;

    logic            w_pick_if;
    logic            w_pick_ls;
    logic            w_expire;
    logic            w_done;
    logic [31:0]     w_fin_data;

    // Load/store normally wins; fetch wins a tie once the streak is exhausted.
    assign w_pick_if = if_req && (!ls_req || (r_streak == STREAK_MAX));
    assign w_pick_ls = ls_req && !w_pick_if;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES < 1) ? 0 : TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_tcnt;

    assign w_expire = ((r_state == BUSY_IF) || (r_state == BUSY_LS))
                      && !mem_ready && (r_tcnt == T_LAST);
`else
    logic w_unused_timeout_cfg;

    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign w_expire = 1'b0;
    assign timeout  = 1'b0;
`endif

    // A watchdog abort completes the transaction like a read of zero.
    assign w_done     = mem_ready || w_expire;
    assign w_fin_data = mem_ready ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_streak  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            if_ack    <= 1'b0;
            ls_ack    <= 1'b0;
            if_rdata  <= '0;
            ls_rdata  <= '0;
`ifdef ARB_TIMEOUT_EN
            r_tcnt    <= '0;
            timeout   <= 1'b0;
`endif
        end else begin
            if_ack <= 1'b0;
            ls_ack <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
`ifdef ARB_TIMEOUT_EN
                    r_tcnt <= '0;
`endif
                    if (w_pick_if) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        mem_wstrb <= '0;
                        r_streak  <= '0;
                        r_state   <= BUSY_IF;
                    end else if (w_pick_ls) begin
                        mem_req   <= 1'b1;
                        mem_we    <= ls_we;
                        mem_addr  <= ls_addr;
                        mem_wdata <= ls_wdata;
                        mem_wstrb <= ls_wstrb;
                        if (if_req && (r_streak != STREAK_MAX)) begin
                            r_streak <= r_streak + 1'b1;
                        end
                        r_state   <= BUSY_LS;
                    end
                end

                BUSY_IF: begin
                    if (w_done) begin
                        mem_req  <= 1'b0;
                        if_rdata <= w_fin_data;
                        if_ack   <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        timeout  <= w_expire;
`endif
                        r_state  <= RESP;
                    end
`ifdef ARB_TIMEOUT_EN
                    else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
`endif
                end

                BUSY_LS: begin
                    if (w_done) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            ls_rdata <= w_fin_data;
                        end
                        ls_ack  <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        timeout <= w_expire;
`endif
                        r_state <= RESP;
                    end
`ifdef ARB_TIMEOUT_EN
                    else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
`endif
                end

                RESP: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    a_ack_exclusive: assert property (@(posedge clk) !(if_ack && ls_ack));

endmodule
